// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the CPU: instruction classes, sequencer states,
// address-register source selects and the bundled control-strobe record.
package cpu_ctrl_pkg;

    localparam int FILL_DEPTH_DEF = 2;
    localparam int WAIT_MAX_DEF   = 15;

    typedef enum logic [2:0] {
        CLS_DP  = 3'd0,
        CLS_LDR = 3'd1,
        CLS_STR = 3'd2,
        CLS_B   = 3'd3,
        CLS_BL  = 3'd4,
        CLS_NOP = 3'd5
    } ins_class_e;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FILL   = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5
    } state_e;

    localparam logic [1:0] ASEL_INC = 2'd0;
    localparam logic [1:0] ASEL_ALU = 2'd1;
    localparam logic [1:0] ASEL_PC  = 2'd2;

    typedef struct packed {
        logic [1:0] addr_sel;
        logic       ir_load;
        logic       mem_write;
        logic       datareg_in;
        logic       reg_write;
        logic       wb_sel;
        logic       link_write;
        logic       pc_change;
        logic       setflags;
        logic       abort;
    } ctrl_t;

    function automatic logic is_mem_class(input logic [2:0] cls);
        return (cls == CLS_LDR) || (cls == CLS_STR);
    endfunction

    function automatic logic is_branch_class(input logic [2:0] cls);
        return (cls == CLS_B) || (cls == CLS_BL);
    endfunction

endpackage

// File: rtl/cycle_sequencer_if.sv
// Decoder/datapath-facing bundle of the cycle sequencer: class and condition
// inputs from the decoder, memory handshake, and the datapath enables.
interface cycle_sequencer_if;

    logic [2:0] ins_class;
    logic       cond_pass;
    logic       setflags_req;
    logic       mem_ready;

    logic [1:0] addr_sel;
    logic       ir_load;
    logic       mem_write;
    logic       datareg_in;
    logic       reg_write;
    logic       wb_sel;
    logic       link_write;
    logic       pc_change;
    logic       setflags;
    logic       abort;
    logic [2:0] state;

    modport master (
        output ins_class, cond_pass, setflags_req, mem_ready,
        input  addr_sel, ir_load, mem_write, datareg_in, reg_write, wb_sel,
               link_write, pc_change, setflags, abort, state
    );

    modport slave (
        input  ins_class, cond_pass, setflags_req, mem_ready,
        output addr_sel, ir_load, mem_write, datareg_in, reg_write, wb_sel,
               link_write, pc_change, setflags, abort, state
    );

endinterface

// File: rtl/wait_timer.sv
// Saturating up-counter with synchronous clear; last_o flags that the next
// increment would reach LIMIT, so callers can act on the LIMIT-th event.
module wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] CNT_LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: stretches loads, stores and
// branches over several cycles and drives the datapath enables.
module cycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int FILL_DEPTH = FILL_DEPTH_DEF,
    parameter int WAIT_MAX   = WAIT_MAX_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    cycle_sequencer_if.slave bus
);

    state_e     state_q;
    state_e     state_d;
    ins_class_e cls_q;
    ins_class_e cls_d;
    ctrl_t      ctrl;

    logic fill_clr;
    logic fill_inc;
    logic fill_last;
    logic wait_clr;
    logic wait_inc;
    logic wait_last;

    // Both counters sit at zero outside their own state, so entering FILL or
    // MEM always starts a fresh count.
    always_comb begin
        fill_clr = (state_q != ST_FILL);
        fill_inc = (state_q == ST_FILL) && bus.mem_ready;
        wait_clr = (state_q != ST_MEM) || ctrl.abort;
        wait_inc = (state_q == ST_MEM) && !bus.mem_ready;
    end

    wait_timer #(
        .LIMIT (FILL_DEPTH)
    ) u_fill_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (fill_clr),
        .inc_i  (fill_inc),
        .last_o (fill_last)
    );

    wait_timer #(
        .LIMIT (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr_i  (wait_clr),
        .inc_i  (wait_inc),
        .last_o (wait_last)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ctrl    = '0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FILL;
            end

            ST_FILL: begin
                ctrl.addr_sel = ASEL_INC;
                ctrl.ir_load  = bus.mem_ready;
                if (bus.mem_ready && fill_last) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // A stalled fetch freezes the instruction in place with no side effects.
                if (bus.mem_ready) begin
                    ctrl.ir_load = 1'b1;
                    if (bus.cond_pass) begin
                        if (bus.ins_class == CLS_DP) begin
                            ctrl.reg_write = 1'b1;
                            ctrl.wb_sel    = 1'b0;
                            ctrl.setflags  = bus.setflags_req;
                        end else if (is_mem_class(bus.ins_class)) begin
                            ctrl.addr_sel   = ASEL_ALU;
                            ctrl.datareg_in = (bus.ins_class == CLS_STR);
                            cls_d           = ins_class_e'(bus.ins_class);
                            state_d         = ST_MEM;
                        end else if (is_branch_class(bus.ins_class)) begin
                            ctrl.addr_sel   = ASEL_PC;
                            ctrl.pc_change  = 1'b1;
                            ctrl.link_write = (bus.ins_class == CLS_BL);
                            state_d         = ST_BRANCH;
                        end
                    end
                end
            end

            ST_MEM: begin
                ctrl.addr_sel  = ASEL_INC;
                ctrl.mem_write = (cls_q == CLS_STR);
                // Completion takes priority over a timeout landing in the same cycle.
                if (bus.mem_ready) begin
                    state_d = (cls_q == CLS_LDR) ? ST_WB : ST_EXEC;
                end else if (wait_last) begin
                    ctrl.abort = 1'b1;
                    state_d    = ST_FILL;
                end
            end

            ST_WB: begin
                ctrl.addr_sel  = ASEL_INC;
                ctrl.reg_write = 1'b1;
                ctrl.wb_sel    = 1'b1;
                state_d        = ST_EXEC;
            end

            ST_BRANCH: begin
                ctrl.addr_sel = ASEL_INC;
                state_d       = ST_FILL;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_RESET;
            cls_q   <= CLS_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    assign bus.addr_sel   = ctrl.addr_sel;
    assign bus.ir_load    = ctrl.ir_load;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.datareg_in = ctrl.datareg_in;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.wb_sel     = ctrl.wb_sel;
    assign bus.link_write = ctrl.link_write;
    assign bus.pc_change  = ctrl.pc_change;
    assign bus.setflags   = ctrl.setflags;
    assign bus.abort      = ctrl.abort;
    assign bus.state      = state_q;

endmodule
